// File: rtl/sdc_host_arb_pkg.sv
// Shared encodings for the two-port SDRAM host arbiter: FSM states, default
// widths and the burst-length convention used by agents and the bench.
package sdc_host_arb_pkg;

    localparam int U_ADDR_MSB = 22;
    localparam int U_DATA_MSB = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    // A request's len field encodes beats-1, so 0..3 means 1..4 beats.
    function automatic logic [2:0] len_to_beats(input logic [1:0] len);
        return {1'b0, len} + 3'd1;
    endfunction

endpackage

// File: rtl/sdc_host_arb_rr_pick.sv
// Two-way round-robin winner selector; the priority pointer lives in the parent.
module sdc_rr_pick (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       win,
    output logic       valid
);

    assign valid = |req;
    assign win   = (&req) ? prio : req[1];

endmodule

// File: rtl/sdc_host_arb.sv
// Round-robin arbiter that serialises whole transactions from two host ports
// onto the single sdr_* host request port of the SDRAM controller.
module sdc_host_arb
    import sdc_host_arb_pkg::*;
#(
    parameter int ADDR_W = U_ADDR_MSB + 1,
    parameter int DATA_W = U_DATA_MSB + 1
) (
    input  logic              mclk,
    input  logic              s_reset,

    input  logic              h0_req,
    input  logic [ADDR_W-1:0] h0_adr,
    input  logic [1:0]        h0_len,
    input  logic              h0_wr_n,
    input  logic [DATA_W-1:0] h0_wr_data,
    input  logic [3:0]        h0_wr_en_n,
    output logic              h0_ack,
    output logic              h0_wr_next,
    output logic              h0_rd_valid,

    input  logic              h1_req,
    input  logic [ADDR_W-1:0] h1_adr,
    input  logic [1:0]        h1_len,
    input  logic              h1_wr_n,
    input  logic [DATA_W-1:0] h1_wr_data,
    input  logic [3:0]        h1_wr_en_n,
    output logic              h1_ack,
    output logic              h1_wr_next,
    output logic              h1_rd_valid,

    output logic [DATA_W-1:0] h_rd_data,

    output logic              sdr_req,
    output logic [ADDR_W-1:0] sdr_req_adr,
    output logic [1:0]        sdr_req_len,
    output logic              sdr_req_wr_n,
    output logic [DATA_W-1:0] sdr_wr_data,
    output logic [3:0]        sdr_wr_en_n,
    input  logic              sdr_req_ack,
    input  logic              sdr_rd_valid,
    input  logic              sdr_wr_next,
    input  logic [DATA_W-1:0] sdr_rd_data,
    input  logic              sdr_init_done
);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic              r_gnt;
    logic              r_prio;
    logic [1:0]        r_beatCnt;
    logic [ADDR_W-1:0] r_reqAdr;
    logic [1:0]        r_reqLen;
    logic              r_reqWrN;
    logic [1:0]        r_ack;

    logic w_win;
    logic w_valid;
    logic w_grant;
    logic w_accept;
    logic w_xfer;
    logic w_wrBeat;
    logic w_rdBeat;
    logic w_beat;
    logic w_lastBeat;

    sdc_rr_pick u_pick (
        .req   ({h1_req, h0_req}),
        .prio  (r_prio),
        .win   (w_win),
        .valid (w_valid)
    );

    assign w_grant    = (r_state == ST_IDLE) && sdr_init_done && w_valid;
    assign w_accept   = (r_state == ST_REQ) && sdr_req_ack;
    assign w_xfer     = (r_state == ST_XFER);
    // Beats of the wrong direction or outside XFER are simply ignored.
    assign w_wrBeat   = w_xfer && !r_reqWrN && sdr_wr_next;
    assign w_rdBeat   = w_xfer && r_reqWrN && sdr_rd_valid;
    assign w_beat     = w_wrBeat || w_rdBeat;
    assign w_lastBeat = w_beat && (r_beatCnt == r_reqLen);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (w_grant)    w_nextState = ST_REQ;
            ST_REQ:  if (w_accept)   w_nextState = ST_XFER;
            ST_XFER: if (w_lastBeat) w_nextState = ST_IDLE;
            default:                 w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (s_reset) r_state <= ST_IDLE;
        else         r_state <= w_nextState;
    end

    // The loser of every grant gets priority next time, giving alternation.
    always_ff @(posedge mclk) begin
        if (s_reset) begin
            r_gnt     <= 1'b0;
            r_prio    <= 1'b0;
            r_beatCnt <= 2'd0;
            r_reqAdr  <= '0;
            r_reqLen  <= 2'd0;
            r_reqWrN  <= 1'b1;
            r_ack     <= 2'b00;
        end else begin
            r_ack <= 2'b00;
            if (w_grant) begin
                r_gnt    <= w_win;
                r_prio   <= ~w_win;
                r_reqAdr <= w_win ? h1_adr  : h0_adr;
                r_reqLen <= w_win ? h1_len  : h0_len;
                r_reqWrN <= w_win ? h1_wr_n : h0_wr_n;
            end
            if (w_accept) begin
                r_ack     <= r_gnt ? 2'b10 : 2'b01;
                r_beatCnt <= 2'd0;
            end else if (w_beat) begin
                r_beatCnt <= r_beatCnt + 2'd1;
            end
        end
    end

    assign sdr_req      = (r_state == ST_REQ);
    assign sdr_req_adr  = r_reqAdr;
    assign sdr_req_len  = r_reqLen;
    assign sdr_req_wr_n = r_reqWrN;
    assign sdr_wr_data  = r_gnt ? h1_wr_data : h0_wr_data;
    assign sdr_wr_en_n  = r_gnt ? h1_wr_en_n : h0_wr_en_n;

    assign h0_ack      = r_ack[0];
    assign h1_ack      = r_ack[1];
    assign h0_wr_next  = w_wrBeat && !r_gnt;
    assign h1_wr_next  = w_wrBeat && r_gnt;
    assign h0_rd_valid = w_rdBeat && !r_gnt;
    assign h1_rd_valid = w_rdBeat && r_gnt;
    assign h_rd_data   = sdr_rd_data;

endmodule

// File: tb/tb_sdc_host_arb.sv
// Directed self-checking bench for sdc_host_arb; the bench plays the SDRAM
// controller side by hand and checks routing, ordering and reset behaviour.
module tb_sdc_host_arb;
    import sdc_host_arb_pkg::*;

    localparam int ADDR_W = U_ADDR_MSB + 1;
    localparam int DATA_W = U_DATA_MSB + 1;

    logic              mclk = 1'b0;
    logic              s_reset = 1'b1;
    logic              h0_req = 1'b0, h1_req = 1'b0;
    logic [ADDR_W-1:0] h0_adr = '0, h1_adr = '0;
    logic [1:0]        h0_len = 2'd0, h1_len = 2'd0;
    logic              h0_wr_n = 1'b1, h1_wr_n = 1'b1;
    logic [DATA_W-1:0] h0_wr_data = 32'h1111_0000, h1_wr_data = 32'h2222_0000;
    logic [3:0]        h0_wr_en_n = 4'b0000, h1_wr_en_n = 4'b1010;
    logic              h0_ack, h0_wr_next, h0_rd_valid;
    logic              h1_ack, h1_wr_next, h1_rd_valid;
    logic [DATA_W-1:0] h_rd_data;
    logic              sdr_req;
    logic [ADDR_W-1:0] sdr_req_adr;
    logic [1:0]        sdr_req_len;
    logic              sdr_req_wr_n;
    logic [DATA_W-1:0] sdr_wr_data;
    logic [3:0]        sdr_wr_en_n;
    logic              sdr_req_ack = 1'b0, sdr_rd_valid = 1'b0, sdr_wr_next = 1'b0;
    logic [DATA_W-1:0] sdr_rd_data = '0;
    logic              sdr_init_done = 1'b0;

    int checks = 0;
    int errors = 0;
    int ackCnt0 = 0;
    int ackCnt1 = 0;

    sdc_host_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .mclk(mclk), .s_reset(s_reset),
        .h0_req(h0_req), .h0_adr(h0_adr), .h0_len(h0_len), .h0_wr_n(h0_wr_n),
        .h0_wr_data(h0_wr_data), .h0_wr_en_n(h0_wr_en_n),
        .h0_ack(h0_ack), .h0_wr_next(h0_wr_next), .h0_rd_valid(h0_rd_valid),
        .h1_req(h1_req), .h1_adr(h1_adr), .h1_len(h1_len), .h1_wr_n(h1_wr_n),
        .h1_wr_data(h1_wr_data), .h1_wr_en_n(h1_wr_en_n),
        .h1_ack(h1_ack), .h1_wr_next(h1_wr_next), .h1_rd_valid(h1_rd_valid),
        .h_rd_data(h_rd_data),
        .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
        .sdr_req_ack(sdr_req_ack), .sdr_rd_valid(sdr_rd_valid), .sdr_wr_next(sdr_wr_next),
        .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (h0_ack) ackCnt0++;
        if (h1_ack) ackCnt1++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge mclk);
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic [ADDR_W-1:0] adr,
                                 input logic [1:0] len, input logic wrN);
        if (port == 0) begin
            h0_req = req; h0_adr = adr; h0_len = len; h0_wr_n = wrN;
        end else begin
            h1_req = req; h1_adr = adr; h1_len = len; h1_wr_n = wrN;
        end
    endtask

    task automatic applyReset();
        s_reset = 1'b1;
        tick();
        tick();
        s_reset = 1'b0;
    endtask

    task automatic waitReq();
        int n = 0;
        while (!sdr_req && n < 50) begin
            tick();
            n++;
        end
        checkOutput("reqSeen", {31'd0, sdr_req}, 32'd1);
    endtask

    task automatic ackReq(input int port);
        sdr_req_ack = 1'b1;
        tick();
        sdr_req_ack = 1'b0;
        #1;
        checkOutput("ackOwner", {31'd0, (port == 0) ? h0_ack : h1_ack}, 32'd1);
        checkOutput("ackOther", {31'd0, (port == 0) ? h1_ack : h0_ack}, 32'd0);
        checkOutput("reqDropOnAck", {31'd0, sdr_req}, 32'd0);
    endtask

    task automatic doBeat(input int port, input bit isRead, input logic [DATA_W-1:0] data);
        logic [DATA_W-1:0] expWd;
        logic [3:0]        expEn;
        expWd = (port == 0) ? h0_wr_data : h1_wr_data;
        expEn = (port == 0) ? h0_wr_en_n : h1_wr_en_n;
        if (isRead) begin
            sdr_rd_valid = 1'b1;
            sdr_rd_data  = data;
        end else begin
            sdr_wr_next = 1'b1;
        end
        #1;
        checkOutput("noReqInXfer", {31'd0, sdr_req}, 32'd0);
        if (isRead) begin
            checkOutput("rdValidOwner", {31'd0, (port == 0) ? h0_rd_valid : h1_rd_valid}, 32'd1);
            checkOutput("rdValidOther", {31'd0, (port == 0) ? h1_rd_valid : h0_rd_valid}, 32'd0);
            checkOutput("rdData", h_rd_data, data);
            checkOutput("wrNextInRead", {31'd0, h0_wr_next | h1_wr_next}, 32'd0);
        end else begin
            checkOutput("wrNextOwner", {31'd0, (port == 0) ? h0_wr_next : h1_wr_next}, 32'd1);
            checkOutput("wrNextOther", {31'd0, (port == 0) ? h1_wr_next : h0_wr_next}, 32'd0);
            checkOutput("wrData", sdr_wr_data, expWd);
            checkOutput("wrEn", {28'd0, sdr_wr_en_n}, {28'd0, expEn});
            checkOutput("rdValidInWrite", {31'd0, h0_rd_valid | h1_rd_valid}, 32'd0);
        end
        tick();
        sdr_rd_valid = 1'b0;
        sdr_wr_next  = 1'b0;
    endtask

    initial begin
        logic reqSeen;

        // Reset state
        applyReset();
        #1;
        checkOutput("rstReq", {31'd0, sdr_req}, 32'd0);
        checkOutput("rstAdr", {9'd0, sdr_req_adr}, 32'd0);
        checkOutput("rstLen", {30'd0, sdr_req_len}, 32'd0);
        checkOutput("rstWrN", {31'd0, sdr_req_wr_n}, 32'd1);
        checkOutput("rstAck", {30'd0, h1_ack, h0_ack}, 32'd0);

        // Init gating
        applyStimulus(0, 1'b1, 23'h00ABCD, 2'd0, 1'b1);
        reqSeen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            #1;
            reqSeen = reqSeen | sdr_req;
        end
        checkOutput("initGate", {31'd0, reqSeen}, 32'd0);
        sdr_init_done = 1'b1;
        tick();
        #1;
        checkOutput("initReq", {31'd0, sdr_req}, 32'd1);
        checkOutput("initAdr", {9'd0, sdr_req_adr}, 32'h00ABCD);
        ackReq(0);
        h0_req = 1'b0;
        doBeat(0, 1'b1, 32'h0BAD_F00D);

        // Single 4-beat read on port 1, request withdrawn before the ack
        #2;
        ackCnt0 = 0;
        ackCnt1 = 0;
        applyStimulus(1, 1'b1, 23'h001234, 2'd3, 1'b1);
        waitReq();
        h1_req = 1'b0;
        checkOutput("rdAdr", {9'd0, sdr_req_adr}, 32'h001234);
        checkOutput("rdLen", {30'd0, sdr_req_len}, 32'd3);
        checkOutput("rdWrN", {31'd0, sdr_req_wr_n}, 32'd1);
        ackReq(1);
        for (int i = 0; i < 4; i++) doBeat(1, 1'b1, 32'hCAFE_0000 + i);
        checkOutput("rdAckCnt1", ackCnt1, 32'd1);
        checkOutput("rdAckCnt0", ackCnt0, 32'd0);

        // Burst lock: port 0 4-beat write, port 1 requests mid-burst
        applyStimulus(0, 1'b1, 23'h000400, 2'd3, 1'b0);
        waitReq();
        checkOutput("lockLen", {30'd0, sdr_req_len}, 32'd3);
        ackReq(0);
        h0_req = 1'b0;
        sdr_rd_valid = 1'b1;
        #1;
        checkOutput("wrongDirRd", {31'd0, h0_rd_valid | h1_rd_valid}, 32'd0);
        tick();
        sdr_rd_valid = 1'b0;
        doBeat(0, 1'b0, '0);
        applyStimulus(1, 1'b1, 23'h000800, 2'd0, 1'b0);
        for (int i = 0; i < 3; i++) doBeat(0, 1'b0, '0);
        #1;
        checkOutput("turnIdle", {31'd0, sdr_req}, 32'd0);
        tick();
        #1;
        checkOutput("turnReq", {31'd0, sdr_req}, 32'd1);
        checkOutput("turnAdr", {9'd0, sdr_req_adr}, 32'h000800);
        ackReq(1);
        h1_req = 1'b0;
        doBeat(1, 1'b0, '0);

        // Contention: alternation starting at port 0 after reset
        applyReset();
        applyStimulus(0, 1'b1, 23'h000010, 2'd0, 1'b0);
        applyStimulus(1, 1'b1, 23'h000020, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            waitReq();
            checkOutput("contAdr", {9'd0, sdr_req_adr}, (i % 2 == 0) ? 32'h10 : 32'h20);
            ackReq(i % 2);
            doBeat(i % 2, 1'b0, '0);
        end
        h0_req = 1'b0;
        h1_req = 1'b0;
        tick();

        // Reset mid-burst after 2 of 4 read beats
        applyStimulus(0, 1'b1, 23'h000055, 2'd3, 1'b1);
        waitReq();
        h0_req = 1'b0;
        ackReq(0);
        doBeat(0, 1'b1, 32'h0000_0001);
        doBeat(0, 1'b1, 32'h0000_0002);
        s_reset = 1'b1;
        sdr_rd_valid = 1'b1;
        sdr_rd_data = 32'h0000_0003;
        tick();
        #1;
        checkOutput("abortReq", {31'd0, sdr_req}, 32'd0);
        checkOutput("abortAdr", {9'd0, sdr_req_adr}, 32'd0);
        checkOutput("abortLen", {30'd0, sdr_req_len}, 32'd0);
        checkOutput("abortWrN", {31'd0, sdr_req_wr_n}, 32'd1);
        checkOutput("abortRdValid", {31'd0, h0_rd_valid | h1_rd_valid}, 32'd0);
        checkOutput("abortAck", {30'd0, h1_ack, h0_ack}, 32'd0);
        checkOutput("abortWrNext", {31'd0, h0_wr_next | h1_wr_next}, 32'd0);
        s_reset = 1'b0;
        sdr_rd_valid = 1'b0;
        applyStimulus(0, 1'b1, 23'h0000AA, 2'd0, 1'b0);
        applyStimulus(1, 1'b1, 23'h0000BB, 2'd0, 1'b0);
        waitReq();
        checkOutput("postRstAdr", {9'd0, sdr_req_adr}, 32'h0000AA);
        ackReq(0);
        h0_req = 1'b0;
        doBeat(0, 1'b0, '0);
        waitReq();
        checkOutput("postRstAdr1", {9'd0, sdr_req_adr}, 32'h0000BB);
        ackReq(1);
        h1_req = 1'b0;
        doBeat(1, 1'b0, '0);

        // Stray beats in IDLE
        tick();
        sdr_rd_valid = 1'b1;
        sdr_wr_next  = 1'b1;
        #1;
        checkOutput("strayRd", {30'd0, h1_rd_valid, h0_rd_valid}, 32'd0);
        checkOutput("strayWr", {30'd0, h1_wr_next, h0_wr_next}, 32'd0);
        tick();
        sdr_rd_valid = 1'b0;
        sdr_wr_next  = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
